// File: rtl/piano_pkg.sv
// Shared codes, judge FSM states and score saturation for the learning-mode piano blocks.
package piano_pkg;

  localparam int               KEY_W      = 4;
  localparam logic [KEY_W-1:0] REST_CODE  = 4'd0;
  localparam logic [KEY_W-1:0] MULTI_CODE = 4'd15;
  localparam logic [7:0]       CNT_MAX    = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } judge_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, then a level that follows the synchronized
// input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      key_level <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      // Any return to the accepted level is a bounce and restarts the count.
      if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        key_level <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_judge.sv
// Debounces user keys, encodes press events and judges them against the
// player's expected note, returning the advance pulse and hit/miss scores.
module key_judge
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000,
  parameter bit SKIP_ON_TIMEOUT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic [3:0]          expected_key,
  input  logic                expected_valid,
  input  logic [NUM_KEYS-1:0] user_keys,
  output logic                correct_key_press,
  output logic                wrong_press,
  output logic                timeout,
  output logic [3:0]          pressed_key,
  output logic [7:0]          score,
  output logic [7:0]          miss_count,
  output logic [1:0]          judge_state
);

  localparam int               TW       = 29;
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KEY_W-1:0] MAX_CODE = KEY_W'(NUM_KEYS);

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_prev;
  logic [NUM_KEYS-1:0] rise;
  logic [KEY_W-1:0]    ev_code;
  logic                ev_any;
  int                  n_ev;
  judge_state_t        state;
  logic [KEY_W-1:0]    exp_q;
  logic [TW-1:0]       tcnt;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (user_keys[i]),
      .key_level (key_level[i])
    );
  end

  assign rise   = key_level & ~key_prev;
  assign ev_any = |rise;

  always_comb begin
    ev_code = REST_CODE;
    n_ev    = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rise[i]) begin
        n_ev    = n_ev + 1;
        ev_code = KEY_W'(i + 1);
      end
    end
    if (n_ev > 1) ev_code = MULTI_CODE;
  end

  // Handshake to the player: correct_key_press, wrong_press and timeout are
  // single-cycle registered pulses with no back-pressure; the player advances
  // on every cycle correct_key_press is high and holds expected_key/valid
  // until it does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      exp_q             <= REST_CODE;
      tcnt              <= '0;
      key_prev          <= '0;
      correct_key_press <= 1'b0;
      wrong_press       <= 1'b0;
      timeout           <= 1'b0;
      pressed_key       <= REST_CODE;
      score             <= '0;
      miss_count        <= '0;
    end else begin
      correct_key_press <= 1'b0;
      wrong_press       <= 1'b0;
      timeout           <= 1'b0;
      key_prev          <= key_level;
      if (ev_any) pressed_key <= ev_code;

      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (expected_valid) begin
              exp_q <= expected_key;
              tcnt  <= '0;
              state <= ARMED;
            end
          end
          ARMED: begin
            tcnt <= tcnt + TW'(1);
            // Priority: rest/invalid note, matching press, timeout, wrong press.
            if (exp_q == REST_CODE || exp_q > MAX_CODE) begin
              correct_key_press <= 1'b1;
              state             <= HOLD;
            end else if (ev_any && ev_code == exp_q) begin
              correct_key_press <= 1'b1;
              score             <= sat_inc(score);
              state             <= HOLD;
            end else if (tcnt == TO_LAST) begin
              timeout    <= 1'b1;
              miss_count <= sat_inc(miss_count);
              if (SKIP_ON_TIMEOUT) begin
                correct_key_press <= 1'b1;
                state             <= HOLD;
              end else begin
                state <= IDLE;
              end
            end else if (ev_any) begin
              wrong_press <= 1'b1;
              miss_count  <= sat_inc(miss_count);
            end
          end
          HOLD: begin
            if (!expected_valid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      if (clear) begin
        score      <= '0;
        miss_count <= '0;
      end
    end
  end

  assign judge_state = state;

endmodule

// File: tb/tb_key_judge.sv
// Directed bench for key_judge: stimulus pushes expected pulse snapshots,
// a negedge monitor pops and compares them whenever a pulse appears.
module tb_key_judge;

  localparam int NK = 7;
  localparam int DB = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_a;
  logic          enable_b;
  logic          clear;
  logic [3:0]    expected_key;
  logic          expected_valid;
  logic [NK-1:0] user_keys;

  logic       corr_a, wrong_a, to_a, corr_b, wrong_b, to_b;
  logic [3:0] pk_a, pk_b;
  logic [7:0] score_a, miss_a, score_b, miss_b;
  logic [1:0] st_a, st_b;

  key_judge #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO),
              .SKIP_ON_TIMEOUT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .clear(clear),
    .expected_key(expected_key), .expected_valid(expected_valid),
    .user_keys(user_keys), .correct_key_press(corr_a), .wrong_press(wrong_a),
    .timeout(to_a), .pressed_key(pk_a), .score(score_a),
    .miss_count(miss_a), .judge_state(st_a)
  );

  key_judge #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO),
              .SKIP_ON_TIMEOUT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .clear(clear),
    .expected_key(expected_key), .expected_valid(expected_valid),
    .user_keys(user_keys), .correct_key_press(corr_b), .wrong_press(wrong_b),
    .timeout(to_b), .pressed_key(pk_b), .score(score_b),
    .miss_count(miss_b), .judge_state(st_b)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [24:0] exp_qa[$];
  logic [24:0] exp_qb[$];
  logic [24:0] got_a, got_b, want_a, want_b;
  int checks = 0;
  int errors = 0;
  int last_a = -1;
  int last_b = -1;
  int m_score = 0;
  int m_miss  = 0;
  logic [3:0] m_pk = 4'd0;

  function automatic logic [24:0] mk(input logic c, input logic w, input logic t,
                                     input logic [3:0] pk, input int sc,
                                     input int ms, input logic [1:0] st);
    return {c, w, t, pk, 8'(sc), 8'(ms), st};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (corr_a || wrong_a || to_a)) begin
      last_a = cyc;
      got_a  = {corr_a, wrong_a, to_a, pk_a, score_a, miss_a, st_a};
      checks++;
      if (exp_qa.size() == 0) begin
        errors++;
        $display("FAIL pulse_a unexpected at cycle %0d: got %h, required no pulse", cyc, got_a);
      end else begin
        want_a = exp_qa.pop_front();
        if (got_a !== want_a) begin
          errors++;
          $display("FAIL pulse_a at cycle %0d: got %h, required %h", cyc, got_a, want_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (corr_b || wrong_b || to_b)) begin
      last_b = cyc;
      got_b  = {corr_b, wrong_b, to_b, pk_b, score_b, miss_b, st_b};
      checks++;
      if (exp_qb.size() == 0) begin
        errors++;
        $display("FAIL pulse_b unexpected at cycle %0d: got %h, required no pulse", cyc, got_b);
      end else begin
        want_b = exp_qb.pop_front();
        if (got_b !== want_b) begin
          errors++;
          $display("FAIL pulse_b at cycle %0d: got %h, required %h", cyc, got_b, want_b);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [NK-1:0] mask);
    user_keys = mask;
    ticks(8);
    user_keys = '0;
    ticks(8);
  endtask

  task automatic arm(input logic [3:0] k);
    expected_key   = k;
    expected_valid = 1'b1;
    ticks(2);
  endtask

  task automatic disarm();
    expected_valid = 1'b0;
    ticks(2);
  endtask

  // ---------------- stimulus ----------------
  int t0;

  initial begin
    rst = 1'b1; enable_a = 1'b0; enable_b = 1'b0; clear = 1'b0;
    expected_key = 4'd0; expected_valid = 1'b0; user_keys = '0;
    ticks(3);
    rst = 1'b0;
    ticks(1);
    check("reset_a", 32'({corr_a, wrong_a, to_a, pk_a, score_a, miss_a, st_a}), 32'd0);
    check("reset_b", 32'({corr_b, wrong_b, to_b, pk_b, score_b, miss_b, st_b}), 32'd0);

    // 1. correct press
    enable_a = 1'b1;
    arm(4'd3);
    check("armed_1", 32'(st_a), 32'd1);
    m_score = 1; m_pk = 4'd3;
    exp_qa.push_back(mk(1'b1, 1'b0, 1'b0, m_pk, m_score, m_miss, 2'd2));
    t0 = cyc;
    user_keys = 7'b0000100;
    ticks(8);
    check("press_latency", 32'(last_a - t0), 32'd7);
    user_keys = '0;
    ticks(8);
    check("hold_1", 32'(st_a), 32'd2);
    disarm();
    check("idle_1", 32'(st_a), 32'd0);

    // 2. bounce, wrong key, then correct key
    arm(4'd5);
    for (int i = 0; i < 5; i++) begin
      user_keys[0] = (i % 2 == 0);
      ticks(2);
    end
    user_keys = '0;
    ticks(8);
    check("bounce_no_event", 32'(pk_a), 32'd3);
    m_miss = 1; m_pk = 4'd1;
    exp_qa.push_back(mk(1'b0, 1'b1, 1'b0, m_pk, m_score, m_miss, 2'd1));
    press(7'b0000001);
    check("wrong_stays_armed", 32'(st_a), 32'd1);
    m_score = 2; m_pk = 4'd5;
    exp_qa.push_back(mk(1'b1, 1'b0, 1'b0, m_pk, m_score, m_miss, 2'd2));
    press(7'b0010000);
    disarm();

    // 3a. timeout with skip
    m_miss = 2;
    exp_qa.push_back(mk(1'b1, 1'b0, 1'b1, m_pk, m_score, m_miss, 2'd2));
    expected_key = 4'd2; expected_valid = 1'b1;
    t0 = cyc;
    ticks(103);
    check("timeout_seen_a", 32'(exp_qa.size()), 32'd0);
    check("timeout_latency_a", 32'(last_a - t0), 32'd101);
    check("timeout_hold_a", 32'(st_a), 32'd2);
    disarm();
    check("timeout_idle_a", 32'(st_a), 32'd0);

    // 3b. timeout without skip (second instance, first one idle)
    enable_a = 1'b0; enable_b = 1'b1;
    exp_qb.push_back(mk(1'b0, 1'b0, 1'b1, 4'd5, 0, 1, 2'd0));
    expected_key = 4'd2; expected_valid = 1'b1;
    t0 = cyc;
    ticks(101);
    expected_valid = 1'b0;
    ticks(2);
    check("timeout_seen_b", 32'(exp_qb.size()), 32'd0);
    check("timeout_latency_b", 32'(last_b - t0), 32'd101);
    check("timeout_idle_b", 32'(st_b), 32'd0);
    enable_b = 1'b0; enable_a = 1'b1;

    // 4. rest note, invalid note, simultaneous keys
    exp_qa.push_back(mk(1'b1, 1'b0, 1'b0, m_pk, m_score, m_miss, 2'd2));
    arm(4'd0);
    ticks(2);
    disarm();
    check("rest_score", 32'(score_a), 32'(m_score));
    exp_qa.push_back(mk(1'b1, 1'b0, 1'b0, m_pk, m_score, m_miss, 2'd2));
    arm(4'd9);
    ticks(2);
    disarm();
    arm(4'd4);
    m_miss = 3; m_pk = 4'd15;
    exp_qa.push_back(mk(1'b0, 1'b1, 1'b0, m_pk, m_score, m_miss, 2'd1));
    press(7'b0101000);
    check("multi_code", 32'(pk_a), 32'd15);
    m_score = 3; m_pk = 4'd4;
    exp_qa.push_back(mk(1'b1, 1'b0, 1'b0, m_pk, m_score, m_miss, 2'd2));
    press(7'b0001000);
    disarm();

    // 5. saturation, clear, reset
    for (int n = 0; n < 260; n++) begin
      if (m_score < 255) m_score++;
      m_pk = 4'd1;
      exp_qa.push_back(mk(1'b1, 1'b0, 1'b0, m_pk, m_score, m_miss, 2'd2));
      arm(4'd1);
      press(7'b0000001);
      disarm();
    end
    check("score_saturated", 32'(score_a), 32'd255);
    arm(4'd1);
    m_score = 0; m_miss = 0;
    exp_qa.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 0, 0, 2'd2));
    user_keys = 7'b0000001;
    ticks(6);
    clear = 1'b1;
    ticks(1);
    clear = 1'b0;
    ticks(1);
    user_keys = '0;
    ticks(8);
    check("clear_score", 32'(score_a), 32'd0);
    check("clear_miss", 32'(miss_a), 32'd0);
    disarm();
    arm(4'd2);
    check("armed_pre_rst", 32'(st_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", 32'({corr_a, wrong_a, to_a, pk_a, score_a, miss_a, st_a}), 32'd0);
    rst = 1'b0;
    check("rst_release_idle", 32'(st_a), 32'd0);
    disarm();
    check("rst_after_idle", 32'(st_a), 32'd0);

    // 6. enable low while armed
    arm(4'd3);
    check("armed_6", 32'(st_a), 32'd1);
    enable_a = 1'b0;
    ticks(1);
    check("disable_idle", 32'(st_a), 32'd0);
    press(7'b0000100);
    check("disable_score", 32'(score_a), 32'd0);
    check("disable_pk", 32'(pk_a), 32'd3);
    check("disable_state", 32'(st_a), 32'd0);
    disarm();

    check("queue_a_empty", 32'(exp_qa.size()), 32'd0);
    check("queue_b_empty", 32'(exp_qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_judge.md
Name: key_judge

Overview:
- Learning-mode counterpart to the song player: it receives the player's expected note (key, key_on) and the user's physical key inputs.
- Debounces the keys, encodes press events and judges each one against the expected note.
- Returns the one-cycle correct_key_press handshake that advances the player, with optional skip on timeout.
- Keeps saturating hit and miss scores for display.

Parameters:
- NUM_KEYS, 7: number of user keys; key code k (1..NUM_KEYS) maps to user_keys[k-1].
- DEBOUNCE_CYCLES, 2_000_000: cycles a synchronized key level must stay stable before it is accepted (20 ms at 100 MHz).
- TIMEOUT_CYCLES, 500_000_000: cycles allowed in ARMED before a timeout (5 s).
- SKIP_ON_TIMEOUT, 1: 1 means a timeout also pulses correct_key_press so the song continues.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  learning mode active; low forces IDLE.
- clear  in  1  synchronous clear of score and miss_count.
- expected_key  in  4  note code from the player; 0 means rest.
- expected_valid  in  1  player key_on; expected_key is meaningful while high.
- user_keys  in  NUM_KEYS  raw, asynchronous, active-high key inputs.
- correct_key_press  out  1  one-cycle advance pulse to the player.
- wrong_press  out  1  one-cycle pulse on a mismatched press.
- timeout  out  1  one-cycle pulse when TIMEOUT_CYCLES expires.
- pressed_key  out  4  code of the last accepted press event; 0 before any press.
- score  out  8  correct presses, saturating at 255.
- miss_count  out  8  wrong presses plus timeouts, saturating at 255.
- judge_state  out  2  FSM state for LEDs: 0 IDLE, 1 ARMED, 2 HOLD.

Behaviour:
- Reset: all outputs 0, FSM IDLE, every counter 0, debounced levels 0, synchronizers 0.
- Input path, per key:
  - 2-flop synchronizer, then debounce.
  - The debounced level follows the synchronized level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts that key's count.
- Press event: debounced rising edge.
  - Exactly one event in a cycle gives code = index+1.
  - Two or more events in the same cycle give code 15, which never matches.
  - Releases generate nothing.
- pressed_key updates on every press event, in any state.
- FSM:
  - IDLE: when enable=1 and expected_valid=1, latch expected_key into exp_q, clear the timeout counter, go to ARMED.
  - ARMED, exp_q = 0 or exp_q > NUM_KEYS (rest or invalid): pulse correct_key_press next cycle, score unchanged, go to HOLD.
  - ARMED, press event with code = exp_q: correct_key_press = 1 in the following cycle (latency 1 from the event), score+1, go to HOLD.
  - ARMED, press event with code ≠ exp_q: wrong_press pulse, miss_count+1, stay in ARMED, timeout counter not reset.
  - ARMED, timeout counter reaches TIMEOUT_CYCLES-1: timeout pulse, miss_count+1, go to HOLD. If SKIP_ON_TIMEOUT=1, correct_key_press pulses in the same cycle as timeout; otherwise go to IDLE instead of HOLD.
  - ARMED, correct event and timeout in the same cycle: the press wins; no timeout, no miss.
  - HOLD: wait for expected_valid=0, then go to IDLE. This prevents re-accepting the same note while key_on stays high. Press events in HOLD are ignored for judging.
  - enable=0 in any state: next state IDLE, no pulses, score and miss_count hold.
  - A change of expected_key while in ARMED is ignored; exp_q stays latched.
- All three pulses are exactly one cycle wide. correct_key_press and wrong_press are never high in the same cycle.
- Arithmetic:
  - score and miss_count are 8-bit; at 255 they stay 255.
  - clear has priority over increments in the same cycle.
- Timeout counter: 29 bits, counts only in ARMED, cleared on entry to ARMED.
- Asserting rst mid-operation immediately aborts; the first cycle after release is IDLE with zeroed outputs.

Decomposition:
- Shared package (piano_pkg):
  - KEY_W=4, REST_CODE=0, MULTI_CODE=15.
  - judge_state enum {IDLE, ARMED, HOLD}.
  - CNT_MAX=8'd255.
- Sub-module key_debounce (synchronizer plus stable-counter, parameter DEBOUNCE_CYCLES), instantiated NUM_KEYS times by a generate loop. The encoder and FSM stay in key_judge.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=100.
1. Correct press:
   - Stimulus: expected_key=3, expected_valid=1; clean press on user_keys[2].
   - Response: correct_key_press high exactly 1 cycle, 1 cycle after the debounced edge; score=1; pressed_key=3; state HOLD.
   - Then drop expected_valid: state goes to IDLE.
2. Bounce then wrong key:
   - Stimulus: user_keys[0] toggles every 2 cycles for 10 cycles; no event occurs. Then a stable press of key 1 while exp=5.
   - Response: wrong_press pulse, miss_count=1, still ARMED.
   - Then press key 5: correct_key_press, score=1.
3. Timeout with SKIP_ON_TIMEOUT=1:
   - Stimulus: exp=2, no press.
   - Response: at cycle 100 in ARMED, timeout and correct_key_press both pulse in the same cycle; miss_count=1.
   - Repeat with SKIP_ON_TIMEOUT=0: only timeout pulses and the FSM returns to IDLE.
4. Rest note and simultaneous keys:
   - Stimulus: exp=0.
   - Response: auto correct_key_press with score unchanged.
   - Stimulus: exp=4 and keys 4 and 6 debounce-rise in the same cycle.
   - Response: wrong_press, pressed_key=15.
5. Saturation, clear and reset:
   - Stimulus: 260 correct presses.
   - Response: score=255.
   - Stimulus: clear coinciding with a correct press.
   - Response: score=0.
   - Stimulus: assert rst while in ARMED.
   - Response: all outputs 0, state IDLE.
6. enable low mid-ARMED:
   - Stimulus: press the correct key while enable=0.
   - Response: no pulse, score unchanged, state IDLE.
